// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
//
// Sequencing controller for a WIDTH-bit serial-in shift register. A parallel
// word is taken through a start/ready handshake and fed MSB-first onto the
// register's serial input, one bit per shift cycle, with PAUSE idle cycles
// between consecutive shifts. After the last shift the register's parallel
// output is sampled, compared against the loaded word, and a one-cycle done
// pulse is issued.
//
// Parameters:
//   WIDTH  word / register width, legal 2..8
//   PAUSE  idle cycles between consecutive shifts, legal 0..15
//
// Ports:
//   CLK     in   clock, all state changes on the rising edge
//   RST     in   synchronous active-high reset
//   start   in   load request, accepted only when start & ready
//   din     in   parallel word, captured on the accept edge
//   abort   in   synchronous abort of a transfer in progress
//   q       in   parallel output of the shift register
//   ready   out  high exactly in IDLE
//   busy    out  high in every state except IDLE
//   sh_d    out  serial data to the register
//   sh_en   out  shift-enable qualifier for the register
//   dout    out  sampled register contents, valid from DONE until next accept
//   done    out  one-cycle completion pulse
//   match   out  dout == loaded word, valid with done and held with dout
//
// State table:
//   state   | meaning
//   IDLE    | waiting for start, ready=1
//   SHIFT   | drive one word bit with sh_en=1
//   GAP     | PAUSE idle cycles between shifts
//   CHECK   | sample q into dout and compare against word
//   DONE    | one-cycle done pulse, abort ignored here
// ---------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int PAUSE = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             abort,
    input  logic [WIDTH-1:0] q,
    output logic             ready,
    output logic             busy,
    output logic             sh_d,
    output logic             sh_en,
    output logic [WIDTH-1:0] dout,
    output logic             done,
    output logic             match
);

    // One spare bit on the bit counter so it can never wrap within a transfer.
    localparam int BW = $clog2(WIDTH) + 1;
    localparam logic [BW-1:0]    LAST_BIT = BW'(WIDTH - 1);
    localparam logic [BW-1:0]    ONE_BIT  = BW'(1);
    localparam logic [3:0]       PAUSE_LD = 4'(PAUSE);
    localparam logic [WIDTH-1:0] MSB_ONE  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_GAP   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] word_q,   word_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [3:0]       pcnt_q,   pcnt_d;

    logic             ready_q,  ready_d;
    logic             busy_q,   busy_d;
    logic             sh_d_q,   sh_d_d;
    logic             sh_en_q,  sh_en_d;
    logic [WIDTH-1:0] dout_q,   dout_d;
    logic             done_q,   done_d;
    logic             match_q,  match_d;

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            word_q   <= '0;
            bitcnt_q <= '0;
            pcnt_q   <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            sh_d_q   <= 1'b0;
            sh_en_q  <= 1'b0;
            dout_q   <= '0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            bitcnt_q <= bitcnt_d;
            pcnt_q   <= pcnt_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            sh_d_q   <= sh_d_d;
            sh_en_q  <= sh_en_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            match_q  <= match_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        bitcnt_d = bitcnt_q;
        pcnt_d   = pcnt_q;

        case (state_q)
            S_IDLE: begin
                // abort beats a simultaneous start: nothing is captured
                if (start && !abort) begin
                    state_d  = S_SHIFT;
                    word_d   = din;
                    bitcnt_d = '0;
                end
            end

            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    bitcnt_d = bitcnt_q + ONE_BIT;
                    if (bitcnt_q == LAST_BIT) begin
                        state_d = S_CHECK;
                    end else if (PAUSE > 0) begin
                        pcnt_d  = PAUSE_LD;
                        state_d = S_GAP;
                    end
                end
            end

            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    // counter is loaded with PAUSE, so leaving at 1 gives
                    // exactly PAUSE gap cycles
                    pcnt_d = pcnt_q - 4'd1;
                    if (pcnt_q == 4'd1) begin
                        state_d = S_SHIFT;
                    end
                end
            end

            S_CHECK: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic. Outputs are registered, so their next values are decoded
    // from the next state; this puts the first shift in the cycle right after
    // the accept edge.
    // -----------------------------------------------------------------------
    always_comb begin
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        sh_en_d = (state_d == S_SHIFT);
        done_d  = (state_d == S_DONE);

        // MSB-first: select word bit WIDTH-1-bitcnt
        sh_d_d  = sh_en_d && ((word_d & (MSB_ONE >> bitcnt_d)) != '0);

        dout_d  = dout_q;
        match_d = match_q;

        // accept clears the old comparison result; dout holds until CHECK
        if (state_q == S_IDLE && state_d == S_SHIFT) begin
            match_d = 1'b0;
        end

        // an abort during CHECK leaves dout/match untouched
        if (state_q == S_CHECK && state_d == S_DONE) begin
            dout_d  = q;
            match_d = (q == word_q);
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign sh_d  = sh_d_q;
    assign sh_en = sh_en_q;
    assign dout  = dout_q;
    assign done  = done_q;
    assign match = match_q;

endmodule
